neopixel_receiver: RTL and testbench

Decodes a WS2812-style single-wire NeoPixel stream back into 24-bit pixel words and frame events. It sits on the `axi_clock` domain beside `neopixel`, used for loopback checking of `neopixel_drive` and as the input stage for chained or externally driven strips. The decoder measures each high pulse to classify bits and detects the latch gap to close a frame. Decoded pixels leave on a one-cycle write strobe in the same data/address shape the control path uses.

---
 rtl/neopixel_pkg.sv | 33 +++
 rtl/neopixel_pulse_meter.sv | 67 ++++++
 rtl/neopixel_receiver.sv | 169 ++++++++++++++++
 tb/tb_neopixel_receiver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared NeoPixel (WS2812) timing constants, ns-to-cycle threshold helpers,
// and the receiver state encoding.
package neopixel_pkg;

    // Nominal WS2812 waveform, also used by the transmitter.
    localparam int T0H_NS    = 400;
    localparam int T1H_NS    = 800;
    localparam int TBIT_NS   = 1250;
    localparam int TRESET_NS = 50000;

    // Receiver classification windows.
    localparam int TMIN_NS   = 100;
    localparam int TSPLIT_NS = 600;
    localparam int TMAX_NS   = 1200;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_e;

    function automatic int ns_to_cycles(input longint freq_hz, input int ns);
        return int'((freq_hz * longint'(ns)) / longint'(1000000000));
    endfunction

    function automatic int reset_cycles(input longint freq_hz, input int sim_mode);
        int c;
        c = ns_to_cycles(freq_hz, TRESET_NS);
        return (sim_mode != 0) ? c / 10 : c;
    endfunction

endpackage

// File: rtl/neopixel_pulse_meter.sv
// Synchronises the serial line, detects edges and measures high/low run lengths.
// Emits fall with the high length, and a one-shot gap when the line has been low T_RESET cycles.
module neopixel_pulse_meter
    import neopixel_pkg::*;
#(
    parameter int T_MAX   = 60,
    parameter int T_RESET = 2500,
    parameter int CNT_W   = 12
) (
    input  logic             axi_clock,
    input  logic             axi_resetn,
    input  logic             line_in,
    output logic             rise,
    output logic             fall,
    output logic             gap,
    output logic [CNT_W-1:0] high_cycles
);

    localparam logic [CNT_W-1:0] HIGH_SAT  = CNT_W'(T_MAX + 1);
    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(T_RESET);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             line_q, line_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic             gap_q, gap_d;

    always_comb begin
        sync1_d    = line_in;
        sync2_d    = sync1_q;
        line_d     = sync2_q;
        high_cnt_d = '0;
        low_cnt_d  = '0;
        if (sync2_q) begin
            high_cnt_d = (high_cnt_q == HIGH_SAT) ? HIGH_SAT : high_cnt_q + CNT_W'(1);
        end else begin
            low_cnt_d = (low_cnt_q == RESET_CNT) ? RESET_CNT : low_cnt_q + CNT_W'(1);
        end
        // Fires once, on the cycle the low counter first reaches T_RESET.
        gap_d = (low_cnt_d == RESET_CNT) && (low_cnt_q != RESET_CNT);
    end

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            line_q     <= 1'b0;
            high_cnt_q <= '0;
            low_cnt_q  <= '0;
            gap_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            line_q     <= line_d;
            high_cnt_q <= high_cnt_d;
            low_cnt_q  <= low_cnt_d;
            gap_q      <= gap_d;
        end
    end

    assign rise        = sync2_q & ~line_q;
    assign fall        = ~sync2_q & line_q;
    assign gap         = gap_q;
    assign high_cycles = high_cnt_q;

endmodule

// File: rtl/neopixel_receiver.sv
// WS2812 stream decoder: classifies high pulses into bits, assembles 24-bit pixels
// and closes frames on the latch gap, aborting on out-of-window pulses.
module neopixel_receiver
    import neopixel_pkg::*;
#(
    parameter int C_FREQ_HZ  = 50000000,
    parameter int C_PIXELS   = 12,
    parameter int C_SIM_MODE = 0
) (
    input  logic        axi_clock,
    input  logic        axi_resetn,
    input  logic        neopixel_in,
    output logic        pixel_valid,
    output logic [31:0] pixel_address,
    output logic [31:0] pixel_data,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic [2:0]  frame_status
);

    localparam int T_MIN   = ns_to_cycles(longint'(C_FREQ_HZ), TMIN_NS);
    localparam int T_SPLIT = ns_to_cycles(longint'(C_FREQ_HZ), TSPLIT_NS);
    localparam int T_MAX   = ns_to_cycles(longint'(C_FREQ_HZ), TMAX_NS);
    localparam int T_RESET = reset_cycles(longint'(C_FREQ_HZ), C_SIM_MODE);
    localparam int CNT_W   = $clog2(ns_to_cycles(longint'(C_FREQ_HZ), TRESET_NS) + 1);

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0] SPLIT_C = CNT_W'(T_SPLIT);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(T_MAX);

    logic             rise, fall, gap;
    logic [CNT_W-1:0] high_cycles;

    neopixel_pulse_meter #(
        .T_MAX   (T_MAX),
        .T_RESET (T_RESET),
        .CNT_W   (CNT_W)
    ) u_meter (
        .axi_clock   (axi_clock),
        .axi_resetn  (axi_resetn),
        .line_in     (neopixel_in),
        .rise        (rise),
        .fall        (fall),
        .gap         (gap),
        .high_cycles (high_cycles)
    );

    rx_state_e   state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic        ovf_q, ovf_d;
    logic [23:0] shift_q, shift_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [31:0] pixel_address_q, pixel_address_d;
    logic [31:0] pixel_data_q, pixel_data_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_pixels_q, frame_pixels_d;
    logic [2:0]  frame_status_q, frame_status_d;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        pix_cnt_d       = pix_cnt_q;
        ovf_d           = ovf_q;
        shift_d         = shift_q;
        pixel_valid_d   = 1'b0;
        pixel_address_d = pixel_address_q;
        pixel_data_d    = pixel_data_q;
        frame_done_d    = 1'b0;
        frame_pixels_d  = frame_pixels_q;
        frame_status_d  = frame_status_q;

        case (state_q)
            ST_SYNC: begin
                if (gap) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d   = ST_HIGH;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    ovf_d     = 1'b0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (high_cycles < MIN_C || high_cycles > MAX_C) begin
                        frame_done_d   = 1'b1;
                        frame_pixels_d = pix_cnt_q;
                        frame_status_d = {ovf_q, 1'b0, 1'b1};
                        state_d        = ST_SYNC;
                    end else begin
                        shift_d = {shift_q[22:0], (high_cycles >= SPLIT_C)};
                        state_d = ST_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (pix_cnt_q < 16'(C_PIXELS)) begin
                                pixel_valid_d   = 1'b1;
                                pixel_address_d = 32'(pix_cnt_q);
                                pixel_data_d    = {8'h00, shift_d};
                                pix_cnt_d       = pix_cnt_q + 16'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            ST_LOW: begin
                if (gap) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    frame_status_d = {ovf_q, (bit_cnt_q != 5'd0), 1'b0};
                    state_d        = ST_IDLE;
                end
                // A rise coinciding with the gap starts the next frame straight away.
                if (rise) begin
                    state_d = ST_HIGH;
                    if (gap) begin
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                        ovf_d     = 1'b0;
                    end
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge axi_clock or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q         <= ST_SYNC;
            bit_cnt_q       <= '0;
            pix_cnt_q       <= '0;
            ovf_q           <= 1'b0;
            shift_q         <= '0;
            pixel_valid_q   <= 1'b0;
            pixel_address_q <= '0;
            pixel_data_q    <= '0;
            frame_done_q    <= 1'b0;
            frame_pixels_q  <= '0;
            frame_status_q  <= '0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            pix_cnt_q       <= pix_cnt_d;
            ovf_q           <= ovf_d;
            shift_q         <= shift_d;
            pixel_valid_q   <= pixel_valid_d;
            pixel_address_q <= pixel_address_d;
            pixel_data_q    <= pixel_data_d;
            frame_done_q    <= frame_done_d;
            frame_pixels_q  <= frame_pixels_d;
            frame_status_q  <= frame_status_d;
        end
    end

    assign pixel_valid   = pixel_valid_q;
    assign pixel_address = pixel_address_q;
    assign pixel_data    = pixel_data_q;
    assign frame_done    = frame_done_q;
    assign frame_pixels  = frame_pixels_q;
    assign frame_status  = frame_status_q;

endmodule

// File: tb/tb_neopixel_receiver.sv
// Directed bench for neopixel_receiver: table of whole-frame vectors plus
// hand-written glitch, stuck-high and reset sequences.
module tb_neopixel_receiver;

    localparam int T_RESET = 2500;
    localparam int BIT_PER = 62;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        neopixel_in;
    logic        pixel_valid;
    logic [31:0] pixel_address;
    logic [31:0] pixel_data;
    logic        frame_done;
    logic [15:0] frame_pixels;
    logic [2:0]  frame_status;

    neopixel_receiver #(
        .C_FREQ_HZ  (50000000),
        .C_PIXELS   (12),
        .C_SIM_MODE (0)
    ) dut (
        .axi_clock     (clk),
        .axi_resetn    (rst_n),
        .neopixel_in   (neopixel_in),
        .pixel_valid   (pixel_valid),
        .pixel_address (pixel_address),
        .pixel_data    (pixel_data),
        .frame_done    (frame_done),
        .frame_pixels  (frame_pixels),
        .frame_status  (frame_status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;
    int last_fall = 0;

    int          strb_cyc[$];
    logic [31:0] strb_addr[$];
    logic [31:0] strb_data[$];
    int          fd_cyc[$];
    logic [15:0] fd_pix[$];
    logic [2:0]  fd_stat[$];
    int          pix_falls[$];

    typedef struct {
        string       name;
        int          n_bits;
        int          exp_strobes;
        logic [15:0] exp_pixels;
        logic [2:0]  exp_status;
    } vec_t;

    vec_t vecs[4];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pixel_valid === 1'b1 || frame_done === 1'b1)
            check("no_overlap", {31'd0, pixel_valid & frame_done}, 32'd0);
        if (pixel_valid === 1'b1) begin
            strb_cyc.push_back(cycle_cnt);
            strb_addr.push_back(pixel_address);
            strb_data.push_back(pixel_data);
        end
        if (frame_done === 1'b1) begin
            fd_cyc.push_back(cycle_cnt);
            fd_pix.push_back(frame_pixels);
            fd_stat.push_back(frame_status);
        end
    end

    function automatic logic [23:0] colour(input int k);
        logic [23:0] m;
        m = 24'(k) * 24'h111111;
        return 24'hA5C33C ^ m;
    endfunction

    task automatic clear_logs();
        strb_cyc.delete(); strb_addr.delete(); strb_data.delete();
        fd_cyc.delete(); fd_pix.delete(); fd_stat.delete(); pix_falls.delete();
    endtask

    // Called on a negedge; leaves the line low on a negedge.
    task automatic send_pulse(input int high, input int low);
        neopixel_in = 1'b1;
        repeat (high) @(negedge clk);
        neopixel_in = 1'b0;
        last_fall = cycle_cnt;
        repeat (low) @(negedge clk);
    endtask

    task automatic send_stream(input int n_bits, input int base);
        logic [23:0] c;
        int h;
        for (int j = 0; j < n_bits; j++) begin
            c = colour(base + j / 24);
            h = c[23 - (j % 24)] ? 40 : 20;
            send_pulse(h, BIT_PER - h);
            if ((j % 24) == 23) pix_falls.push_back(last_fall);
        end
    endtask

    task automatic wait_frame(input int bound);
        for (int i = 0; i < bound && fd_cyc.size() == 0; i++) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pixel_valid"},   {31'd0, pixel_valid}, 32'd0);
        check({tag, "_pixel_address"}, pixel_address, 32'd0);
        check({tag, "_pixel_data"},    pixel_data, 32'd0);
        check({tag, "_frame_done"},    {31'd0, frame_done}, 32'd0);
        check({tag, "_frame_pixels"},  {16'd0, frame_pixels}, 32'd0);
        check({tag, "_frame_status"},  {29'd0, frame_status}, 32'd0);
    endtask

    task automatic check_strobes(input string tag, input int n, input int base);
        check({tag, "_strobes"}, strb_addr.size(), n);
        for (int i = 0; i < n && i < strb_addr.size(); i++) begin
            check({tag, "_addr"}, strb_addr[i], i);
            check({tag, "_data"}, strb_data[i], {8'h00, colour(base + i)});
            if (i < pix_falls.size())
                check({tag, "_pix_latency"}, strb_cyc[i] - pix_falls[i], 3);
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] pix, input logic [2:0] st,
                               input int latency);
        check({tag, "_frame_done_count"}, fd_cyc.size(), 1);
        if (fd_cyc.size() > 0) begin
            check({tag, "_frame_pixels"}, {16'd0, fd_pix[0]}, {16'd0, pix});
            check({tag, "_frame_status"}, {29'd0, fd_stat[0]}, {29'd0, st});
            check({tag, "_frame_latency"}, fd_cyc[0] - last_fall, latency);
        end
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{name: "single",  n_bits: 24,  exp_strobes: 1,  exp_pixels: 16'd1,  exp_status: 3'b000};
        vecs[1] = '{name: "full",    n_bits: 288, exp_strobes: 12, exp_pixels: 16'd12, exp_status: 3'b000};
        vecs[2] = '{name: "ovf",     n_bits: 312, exp_strobes: 12, exp_pixels: 16'd12, exp_status: 3'b100};
        vecs[3] = '{name: "partial", n_bits: 30,  exp_strobes: 1,  exp_pixels: 16'd1,  exp_status: 3'b010};

        rst_n = 1'b0;
        neopixel_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (T_RESET + 100) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            clear_logs();
            send_stream(vecs[v].n_bits, 0);
            wait_frame(T_RESET + 100);
            check_strobes(vecs[v].name, vecs[v].exp_strobes, 0);
            check_frame(vecs[v].name, vecs[v].exp_pixels, vecs[v].exp_status, T_RESET + 3);
        end
        check("held_frame_pixels", {16'd0, frame_pixels}, 32'd1);
        check("held_frame_status", {29'd0, frame_status}, 32'd2);

        // Runt pulse mid-frame, then a frame sent before the resync gap is ignored.
        clear_logs();
        send_stream(10, 5);
        send_pulse(3, 0);
        wait_frame(20);
        check_frame("runt", 16'd0, 3'b001, 3);
        check("runt_strobes", strb_addr.size(), 0);
        repeat (10) @(negedge clk);
        send_stream(24, 6);
        repeat (T_RESET + 100) @(negedge clk);
        check("sync_strobes", strb_addr.size(), 0);
        check("sync_frame_done_count", fd_cyc.size(), 1);
        clear_logs();
        send_stream(24, 7);
        wait_frame(T_RESET + 100);
        check_strobes("resync", 1, 7);
        check_frame("resync", 16'd1, 3'b000, T_RESET + 3);

        // Stuck-high after one good pixel aborts only at its falling edge.
        clear_logs();
        send_stream(27, 8);
        send_pulse(70, 0);
        wait_frame(20);
        check_strobes("stuck", 1, 8);
        check_frame("stuck", 16'd1, 3'b001, 3);

        // Reset in the middle of bit 10, released while the line toggles.
        repeat (T_RESET + 100) @(negedge clk);
        clear_logs();
        send_stream(10, 2);
        neopixel_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        neopixel_in = 1'b0;
        repeat (20) @(negedge clk);
        send_stream(20, 4);
        repeat (T_RESET + 100) @(negedge clk);
        check("midreset_strobes", strb_addr.size(), 0);
        check("midreset_frame_done_count", fd_cyc.size(), 0);
        clear_logs();
        send_stream(24, 3);
        wait_frame(T_RESET + 100);
        check_strobes("after_reset", 1, 3);
        check_frame("after_reset", 16'd1, 3'b000, T_RESET + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
